// File: rtl/fp_control_unit_if.sv
// Control/status bundle between fp_control_unit and the FP datapath and requester.
// The control unit sits on the master side; the datapath/requester uses slave.
interface fp_control_unit_if;
  logic       start;
  logic       op;
  logic       sign_1, sign_2;
  logic [7:0] exp_1, exp_2;
  logic [7:0] saida_registrador;
  logic [7:0] tamanhoShift;
  logic       directionShift;
  logic       overflow;
  logic [4:0] tamanho, tamanho2;
  logic [7:0] tamanho3;
  logic       soma_multiplica_small_ula, soma_multiplica_big_ula;
  logic       decisor_mux_expoente_escolhido, decisor_mux_saida_big_ula;
  logic       decisor_shift_right_left;
  logic       subtrador_big_ula, subtrador_Somador_subtrador;
  logic       load;
  logic       sign_out;
  logic       busy;
  logic       done;

  modport master (
    input  start, op, sign_1, sign_2, exp_1, exp_2,
           saida_registrador, tamanhoShift, directionShift, overflow,
    output tamanho, tamanho2, tamanho3,
           soma_multiplica_small_ula, soma_multiplica_big_ula,
           decisor_mux_expoente_escolhido, decisor_mux_saida_big_ula,
           decisor_shift_right_left, subtrador_big_ula, subtrador_Somador_subtrador,
           load, sign_out, busy, done
  );

  modport slave (
    output start, op, sign_1, sign_2, exp_1, exp_2,
           saida_registrador, tamanhoShift, directionShift, overflow,
    input  tamanho, tamanho2, tamanho3,
           soma_multiplica_small_ula, soma_multiplica_big_ula,
           decisor_mux_expoente_escolhido, decisor_mux_saida_big_ula,
           decisor_shift_right_left, subtrador_big_ula, subtrador_Somador_subtrador,
           load, sign_out, busy, done
  );
endinterface

// File: rtl/fp_control_unit.sv
// Moore sequencer for the FP add/multiply datapath. Every output is a register
// loaded with the value belonging to the state being entered.
module fp_control_unit #(
  parameter logic [7:0] BIAS      = 8'd127,
  parameter logic [4:0] MAX_SHIFT = 5'd31
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXP, S_ALIGN, S_EXPL, S_NORM, S_CHK, S_OVF, S_DONE
  } state_e;

  state_e     state_q;
  logic       phase_q;
  logic       op_q, s1_q, s2_q;
  logic [7:0] e1_q, e2_q;

  logic [4:0] tam_q, tam2_q;
  logic [7:0] tam3_q;
  logic       smu_q, mux_exp_q, mux_big_q, shift_q, sub_big_q, sub_ss_q;
  logic       load_q, sign_q, busy_q, done_q;

  function automatic logic [4:0] sat5(input logic [7:0] x);
    return (x > {3'b000, MAX_SHIFT}) ? MAX_SHIFT : x[4:0];
  endfunction

  logic [7:0] emax, mul_adj;
  assign emax    = (e1_q > e2_q) ? e1_q : e2_q;
  assign mul_adj = emax - BIAS;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= 1'b0;
      op_q      <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      e1_q      <= '0;
      e2_q      <= '0;
      tam_q     <= '0;
      tam2_q    <= '0;
      tam3_q    <= '0;
      smu_q     <= 1'b0;
      mux_exp_q <= 1'b0;
      mux_big_q <= 1'b0;
      shift_q   <= 1'b0;
      sub_big_q <= 1'b0;
      sub_ss_q  <= 1'b0;
      load_q    <= 1'b0;
      sign_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.start) begin
          state_q <= S_EXP;
          op_q    <= bus.op;
          s1_q    <= bus.sign_1;
          s2_q    <= bus.sign_2;
          e1_q    <= bus.exp_1;
          e2_q    <= bus.exp_2;
          smu_q   <= bus.op;
          sign_q  <= bus.op ? bus.sign_1 : (bus.sign_1 ^ bus.sign_2);
          busy_q  <= 1'b1;
        end
        // Alignment shift and big-ULA subtract stay put until the op retires.
        S_EXP: begin
          state_q   <= S_ALIGN;
          tam_q     <= op_q ? sat5(bus.saida_registrador) : 5'd0;
          sub_big_q <= op_q & (s1_q ^ s2_q);
        end
        S_ALIGN: begin
          state_q   <= S_EXPL;
          phase_q   <= 1'b0;
          mux_exp_q <= 1'b0;
          sub_ss_q  <= 1'b0;
          tam3_q    <= op_q ? bus.saida_registrador : mul_adj;
        end
        S_EXPL: if (!phase_q) begin
          phase_q <= 1'b1;
          load_q  <= 1'b1;
        end else if (op_q) begin
          state_q   <= S_NORM;
          phase_q   <= 1'b0;
          mux_exp_q <= 1'b1;
          mux_big_q <= 1'b0;
          if (bus.directionShift) begin
            shift_q  <= 1'b0;
            tam2_q   <= 5'd1;
            tam3_q   <= 8'd1;
            sub_ss_q <= 1'b0;
          end else begin
            shift_q  <= 1'b1;
            tam2_q   <= sat5(bus.tamanhoShift);
            tam3_q   <= bus.tamanhoShift;
            sub_ss_q <= 1'b1;
          end
        end else begin
          state_q <= S_CHK;
        end
        S_NORM: if (!phase_q) begin
          phase_q <= 1'b1;
          load_q  <= 1'b1;
        end else begin
          state_q <= S_CHK;
        end
        S_CHK: if (bus.overflow) begin
          state_q   <= S_OVF;
          phase_q   <= 1'b0;
          mux_big_q <= 1'b1;
          shift_q   <= 1'b0;
          tam2_q    <= 5'd1;
          mux_exp_q <= 1'b1;
          sub_ss_q  <= 1'b0;
          tam3_q    <= 8'd1;
        end else begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_OVF: if (!phase_q) begin
          phase_q <= 1'b1;
          load_q  <= 1'b1;
        end else begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        // sign_out survives into IDLE; everything else drops back to 0.
        S_DONE: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          tam_q     <= '0;
          tam2_q    <= '0;
          tam3_q    <= '0;
          smu_q     <= 1'b0;
          mux_exp_q <= 1'b0;
          mux_big_q <= 1'b0;
          shift_q   <= 1'b0;
          sub_big_q <= 1'b0;
          sub_ss_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.tamanho                        = tam_q;
  assign bus.tamanho2                       = tam2_q;
  assign bus.tamanho3                       = tam3_q;
  assign bus.soma_multiplica_small_ula      = smu_q;
  assign bus.soma_multiplica_big_ula        = smu_q;
  assign bus.decisor_mux_expoente_escolhido = mux_exp_q;
  assign bus.decisor_mux_saida_big_ula      = mux_big_q;
  assign bus.decisor_shift_right_left       = shift_q;
  assign bus.subtrador_big_ula              = sub_big_q;
  assign bus.subtrador_Somador_subtrador    = sub_ss_q;
  assign bus.load                           = load_q;
  assign bus.sign_out                       = sign_q;
  assign bus.busy                           = busy_q;
  assign bus.done                           = done_q;

endmodule

// File: tb/tb_fp_control_unit.sv
// Bench for fp_control_unit: a per-cycle expected trace built from the operation
// rules is compared against the outputs every cycle, plus literal latency/load pins.
module tb_fp_control_unit;
  logic clk;
  logic rst_n;
  fp_control_unit_if bus();

  fp_control_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] tam;
    logic [4:0] tam2;
    logic [7:0] tam3;
    logic sms, smb, mexp, mbig, shl, sbig, sss, load, sign, busy, done;
  } vec_t;

  vec_t exp_q[$];
  logic last_sign;
  logic mon_en;
  int   errs;
  int   checks;

  function automatic vec_t idle_vec(input logic s);
    vec_t v;
    v = '0;
    v.sign = s;
    return v;
  endfunction

  function automatic logic [4:0] sat(input logic [7:0] x);
    return (x > 8'd31) ? 5'd31 : x[4:0];
  endfunction

  function automatic vec_t dut_vec();
    vec_t v;
    v.tam  = bus.tamanho;
    v.tam2 = bus.tamanho2;
    v.tam3 = bus.tamanho3;
    v.sms  = bus.soma_multiplica_small_ula;
    v.smb  = bus.soma_multiplica_big_ula;
    v.mexp = bus.decisor_mux_expoente_escolhido;
    v.mbig = bus.decisor_mux_saida_big_ula;
    v.shl  = bus.decisor_shift_right_left;
    v.sbig = bus.subtrador_big_ula;
    v.sss  = bus.subtrador_Somador_subtrador;
    v.load = bus.load;
    v.sign = bus.sign_out;
    v.busy = bus.busy;
    v.done = bus.done;
    return v;
  endfunction

  // Expected outputs cycle by cycle, starting with the IDLE cycle in which start is seen.
  function automatic void build(input logic op, s1, s2, input logic [7:0] e1, e2, sr, ts,
                                input logic dir, ov, input int cut);
    vec_t v;
    vec_t tr[$];
    v = idle_vec(last_sign);
    tr.push_back(v);
    v.busy = 1'b1; v.sms = op; v.smb = op; v.sign = op ? s1 : (s1 ^ s2);
    tr.push_back(v);
    v.tam = op ? sat(sr) : 5'd0; v.sbig = op & (s1 ^ s2);
    tr.push_back(v);
    v.mexp = 1'b0; v.sss = 1'b0; v.tam3 = op ? sr : ((e1 > e2 ? e1 : e2) - 8'd127);
    tr.push_back(v); v.load = 1'b1; tr.push_back(v); v.load = 1'b0;
    if (op) begin
      v.mexp = 1'b1; v.mbig = 1'b0;
      if (dir) begin v.shl = 1'b0; v.tam2 = 5'd1; v.tam3 = 8'd1; v.sss = 1'b0; end
      else begin v.shl = 1'b1; v.tam2 = sat(ts); v.tam3 = ts; v.sss = 1'b1; end
      tr.push_back(v); v.load = 1'b1; tr.push_back(v); v.load = 1'b0;
    end
    tr.push_back(v);
    if (ov) begin
      v.mbig = 1'b1; v.shl = 1'b0; v.tam2 = 5'd1; v.mexp = 1'b1; v.sss = 1'b0; v.tam3 = 8'd1;
      tr.push_back(v); v.load = 1'b1; tr.push_back(v); v.load = 1'b0;
    end
    v.done = 1'b1;
    tr.push_back(v);
    if (cut > 0) begin
      while (tr.size() > cut + 1) void'(tr.pop_back());
      tr.push_back('0);
      last_sign = 1'b0;
    end else begin
      last_sign = v.sign;
    end
    foreach (tr[i]) exp_q.push_back(tr[i]);
  endfunction

  always @(negedge clk) begin
    vec_t e, a;
    if (mon_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = idle_vec(last_sign);
      a = dut_vec();
      checks++;
      if (a !== e) begin
        errs++;
        $display("FAIL trace t=%0t actual=%h expected=%h", $time, a, e);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_op(input logic op, s1, s2, input logic [7:0] e1, e2, sr, ts,
                        input logic dir, ov, input int poke, cut, exp_lat, exp_rises,
                        exp_tam, exp_tam3);
    int lat, rises, tam_c3, tam3_c3;
    logic pl;
    lat = 0; rises = 0; pl = 1'b0; tam_c3 = -1; tam3_c3 = -1;
    @(posedge clk); #1;
    bus.op = op; bus.sign_1 = s1; bus.sign_2 = s2; bus.exp_1 = e1; bus.exp_2 = e2;
    bus.saida_registrador = sr; bus.tamanhoShift = ts; bus.directionShift = dir;
    bus.overflow = ov; bus.start = 1'b1;
    build(op, s1, s2, e1, e2, sr, ts, dir, ov, cut);
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      #1;
      bus.start = (c == poke);
      if (c == poke) begin
        bus.op = ~op; bus.sign_1 = ~s1; bus.exp_1 = ~e1; bus.exp_2 = ~e2;
      end
      if (cut > 0 && c == cut) rst_n = 1'b0;
      if (cut > 0 && c == cut + 1) rst_n = 1'b1;
      @(negedge clk);
      if (bus.load && !pl) rises++;
      pl = bus.load;
      if (c == 3) begin tam_c3 = int'(bus.tamanho); tam3_c3 = int'(bus.tamanho3); end
      if (bus.done) lat = c;
      if (bus.done || (cut > 0 && c > cut)) break;
      @(posedge clk);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.overflow = 1'b0;
    if (cut == 0) begin
      chk("latency", lat, exp_lat);
      chk("load_rises", rises, exp_rises);
    end
    chk("tamanho_c3", tam_c3, exp_tam);
    chk("tamanho3_c3", tam3_c3, exp_tam3);
  endtask

  initial begin
    errs = 0; checks = 0; mon_en = 1'b0; last_sign = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 1'b0; bus.sign_1 = 1'b0; bus.sign_2 = 1'b0;
    bus.exp_1 = '0; bus.exp_2 = '0; bus.saida_registrador = '0; bus.tamanhoShift = '0;
    bus.directionShift = 1'b0; bus.overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    //      op  s1 s2 e1     e2     sr     ts     dir ov  poke cut lat rise tam tam3
    run_op(1, 0, 0, 8'h83, 8'h82, 8'd1,  8'd0,  1, 0, 0,  0,  8,  2,  1,  1);
    run_op(1, 1, 0, 8'hA8, 8'h80, 8'd40, 8'd3,  0, 0, 0,  0,  8,  2,  31, 40);
    run_op(1, 0, 1, 8'h90, 8'h8E, 8'd2,  8'd45, 0, 0, 3,  0,  8,  2,  2,  2);
    run_op(0, 1, 0, 8'h83, 8'h82, 8'd1,  8'd0,  0, 0, 6,  0,  6,  1,  0,  4);
    run_op(1, 0, 0, 8'h90, 8'h8E, 8'd2,  8'd0,  1, 1, 10, 0,  10, 3,  2,  2);
    run_op(0, 1, 1, 8'h10, 8'h05, 8'd0,  8'd0,  0, 1, 0,  0,  8,  2,  0,  145);
    run_op(1, 1, 0, 8'h83, 8'h82, 8'd1,  8'd0,  1, 0, 0,  6,  0,  0,  1,  1);
    run_op(1, 0, 0, 8'h83, 8'h82, 8'd1,  8'd0,  1, 0, 0,  0,  8,  2,  1,  1);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL trace_drain actual=%0d expected=0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
